// File: rtl/token_decimation_scheduler.sv
// Decimates N_CH serial token channels, queues per-channel credits and drains them
// round-robin through one valid/ready port. `TOKEN_SCHED_PRIO_EN gives channel 0 strict priority.
module token_decimation_scheduler #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 4,
  parameter int RATIO_W     = 3,
  parameter int RESET_RATIO = 2,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_CH-1:0]    i_tok_in,
  input  logic               i_cfg_we,
  input  logic [RATIO_W-1:0] i_cfg_ratio,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [CH_W-1:0]    o_out_ch,
  output logic [N_CH-1:0]    o_drop,
  output logic               o_idle
);

  // state | meaning
  // EMPTY | nothing offered downstream, out_valid=0
  // HOLD  | token offered on out_ch, waiting for out_ready
  typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

  state_t               r_state;
  logic                 r_out_valid;
  logic [CH_W-1:0]      r_out_ch;
  logic [CH_W-1:0]      r_rr_last;
  logic [RATIO_W-1:0]   r_ratio;

  logic [N_CH-1:0]      w_pend_nz;
  logic [N_CH-1:0]      w_inc;
  logic [N_CH-1:0]      w_dec;
  logic                 w_idle;
  logic                 w_cfg_acc;
  logic [RATIO_W-1:0]   w_ratio_eff;
  logic                 w_take;
  logic [CH_W-1:0]      w_pick;
  logic                 w_rr_upd;

  function automatic logic [CH_W-1:0] rr_pick(input logic [CH_W-1:0] last,
                                               input logic [N_CH-1:0] nz);
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] k;
    int              idx;
    g = '0;
    // Scan backwards so the last hit is the first channel after 'last'
    for (int i = N_CH; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      k = CH_W'(idx);
      if (nz[k]) g = k;
    end
    return g;
  endfunction

  assign w_idle      = !r_out_valid && (w_pend_nz == '0);
  assign w_cfg_acc   = i_cfg_we && w_idle;
  assign w_ratio_eff = w_cfg_acc ? i_cfg_ratio : r_ratio;
  assign w_take      = ((r_state == S_EMPTY) || i_out_ready) && (w_pend_nz != '0);

`ifdef TOKEN_SCHED_PRIO_EN
  assign w_pick   = w_pend_nz[0] ? '0 : rr_pick(r_rr_last, w_pend_nz);
  assign w_rr_upd = !w_pend_nz[0];
`else
  assign w_pick   = rr_pick(r_rr_last, w_pend_nz);
  assign w_rr_upd = 1'b1;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [RATIO_W-1:0] r_ph;
    logic [CNT_W-1:0]   r_pend;
    logic               r_drop;
    logic [RATIO_W-1:0] w_ph_base;
    logic               w_hit;

    // An accepted config write restarts counting from phase 0 in the same cycle
    assign w_ph_base    = w_cfg_acc ? '0 : r_ph;
    assign w_hit        = (w_ratio_eff <= RATIO_W'(1)) ||
                          (w_ph_base == (w_ratio_eff - RATIO_W'(1)));
    assign w_inc[c]     = i_tok_in[c] && w_hit;
    assign w_dec[c]     = w_take && (w_pick == CH_W'(c));
    assign w_pend_nz[c] = (r_pend != '0);
    assign o_drop[c]    = r_drop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_ph   <= '0;
        r_pend <= '0;
        r_drop <= 1'b0;
      end else begin
        if (i_tok_in[c]) r_ph <= w_hit ? '0 : w_ph_base + RATIO_W'(1);
        else             r_ph <= w_ph_base;
        r_drop <= 1'b0;
        if (w_inc[c] && !w_dec[c]) begin
          if (r_pend == '1) r_drop <= 1'b1;
          else              r_pend <= r_pend + CNT_W'(1);
        end else if (!w_inc[c] && w_dec[c]) begin
          r_pend <= r_pend - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ratio <= RATIO_W'(RESET_RATIO);
    else if (w_cfg_acc) r_ratio <= i_cfg_ratio;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_rr_last   <= CH_W'(N_CH - 1);
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= w_pick;
            if (w_rr_upd) r_rr_last <= w_pick;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_out_ready) begin
            if (w_take) begin
              r_out_ch <= w_pick;
              if (w_rr_upd) r_rr_last <= w_pick;
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= S_EMPTY;
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_EMPTY;
        end
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_ch    = r_out_ch;
  assign o_idle      = w_idle;

endmodule
